// File: rtl/seq_detector_param_if.sv
// Serial detector bus: data/control toward the detector, match pulse and counter back.
// The master side drives stimulus; the detector itself uses the slave modport.
interface seq_detector_param_if #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
);
  localparam int LW = $clog2(PAT_W + 1);

  logic             x;
  logic             x_valid;
  logic             load;
  logic [PAT_W-1:0] pat_in;
  logic [LW-1:0]    len_in;
  logic             overlap_en;
  logic             clr_count;
  logic             z;
  logic [CNT_W-1:0] match_count;
  logic             count_sat;

  modport master (
    output x, x_valid, load, pat_in, len_in, overlap_en, clr_count,
    input  z, match_count, count_sat
  );

  modport slave (
    input  x, x_valid, load, pat_in, len_in, overlap_en, clr_count,
    output z, match_count, count_sat
  );
endinterface

// File: rtl/seq_detector_param.sv
// Runtime-programmable serial sequence detector with registered Moore match pulse.
// Optional saturating match counter is built only when SEQDET_COUNT_EN is defined.
module seq_detector_param #(
  parameter int               PAT_W   = 4,
  parameter int               CNT_W   = 8,
  parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(4'b1101),
  parameter int               RST_LEN = 4
) (
  input logic             clk,
  input logic             rst_n,
  seq_detector_param_if.slave bus
);
  localparam int LW = $clog2(PAT_W + 1);

  logic [PAT_W-1:0] hist;
  logic [PAT_W-1:0] pat;
  logic [LW-1:0]    fill;
  logic [LW-1:0]    len;
  logic             z_q;

  logic [PAT_W-1:0] hist_next;
  logic [PAT_W-1:0] mask;
  logic [LW:0]      fill_inc;
  logic [LW-1:0]    fill_next;
  logic [LW-1:0]    len_clamped;
  logic             accept;
  logic             match_now;

  // Match check looks at the history as it will be after shifting in x,
  // so bit 0 of the pattern lines up with the bit arriving on this edge.
  always_comb begin
    accept      = bus.x_valid && !bus.load;
    hist_next   = {hist[PAT_W-2:0], bus.x};
    mask        = ~({PAT_W{1'b1}} << len);
    fill_inc    = {1'b0, fill} + (LW+1)'(1);
    match_now   = accept && (fill_inc >= {1'b0, len}) && (((hist_next ^ pat) & mask) == '0);
    fill_next   = (fill_inc > (LW+1)'(PAT_W)) ? LW'(PAT_W) : fill_inc[LW-1:0];
    if (match_now && !bus.overlap_en)
      fill_next = '0;
    len_clamped = bus.len_in;
    if (bus.len_in == '0)
      len_clamped = LW'(1);
    else if (bus.len_in > LW'(PAT_W))
      len_clamped = LW'(PAT_W);
  end

  // Load wins over a valid sample and flushes history so the new pattern starts clean.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist <= '0;
      fill <= '0;
      pat  <= RST_PAT;
      len  <= LW'(RST_LEN);
      z_q  <= 1'b0;
    end else if (bus.load) begin
      hist <= '0;
      fill <= '0;
      pat  <= bus.pat_in;
      len  <= len_clamped;
      z_q  <= 1'b0;
    end else if (bus.x_valid) begin
      hist <= hist_next;
      fill <= fill_next;
      z_q  <= match_now;
    end else begin
      z_q  <= 1'b0;
    end
  end

  assign bus.z = z_q;

`ifdef SEQDET_COUNT_EN
  logic [CNT_W-1:0] count_q;

  // Clear beats a simultaneous match; the count sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count_q <= '0;
    else if (bus.clr_count)
      count_q <= '0;
    else if (match_now && (count_q != '1))
      count_q <= count_q + CNT_W'(1);
  end

  assign bus.match_count = count_q;
  assign bus.count_sat   = (count_q == '1);
`else
  wire unused_clr_count = bus.clr_count;

  assign bus.match_count = '0;
  assign bus.count_sat   = 1'b0;
`endif

endmodule

// File: doc/seq_detector_param.md
# seq_detector_param

Parametrised, runtime-programmable serial bit-sequence detector with a registered Moore match output. Each accepted input bit is compared against a programmable pattern of 1..PAT_W bits, in overlapping or non-overlapping mode. Matches are counted in an optional saturating counter. Out of reset it behaves as the fixed "1101" detector, so it drops into existing serial-monitor datapaths unchanged.

## Interface
- PAT_W, 4, maximum pattern length in bits (legal 2..32)
- CNT_W, 8, match counter width (legal 1..32)
- RST_PAT, 4'b1101 zero-extended to PAT_W, pattern register value after reset
- RST_LEN, 4, pattern length after reset (1..PAT_W)
- LW = $clog2(PAT_W+1) (localparam)

- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- x  in  1  serial data bit
- x_valid  in  1  x is accepted on this rising edge
- load  in  1  latch pat_in/len_in, flush detection state
- pat_in  in  PAT_W  new pattern; bit 0 = most recent (last-arriving) bit
- len_in  in  LW  new pattern length
- overlap_en  in  1  1 = overlapping matches allowed
- clr_count  in  1  synchronous clear of match counter
- z  out  1  registered match pulse
- match_count  out  CNT_W  saturating number of matches
- count_sat  out  1  match_count equals 2^CNT_W-1

## Operation
- State:
  - hist[PAT_W-1:0]: shift register; new bit enters at bit 0.
  - fill: count of valid history bits, 0..PAT_W, saturating.
  - pat/len: programmed pattern and length.
  - z, match_count.
- Accepted bit (x_valid=1, load=0):
  - hist <= {hist[PAT_W-2:0], x}.
  - match_now = (fill+1 >= len) && ({hist,x} low len bits == pat low len bits).
  - fill <= match_now && !overlap_en ? 0 : min(fill+1, PAT_W).
- Non-overlap mode: after a match, the next match requires len fresh bits.
- z <= match_now on accepted edges; z <= 0 on any other edge. z is therefore a one-cycle pulse per match.
- load=1 (takes precedence over x_valid; the sample on that edge is discarded):
  - pat <= pat_in.
  - len <= len_in clamped: 0 → 1, >PAT_W → PAT_W.
  - hist, fill, z <= 0. match_count is unaffected.
- Counter: on a match, match_count increments, saturating at all-ones. count_sat is combinational from match_count.
  - clr_count=1 forces match_count to 0, even if a match occurs on the same edge. z still pulses.
- overlap_en is sampled on each accepted edge; changing it mid-stream affects only the next match's fill update.
- Reset values: z=0, match_count=0, count_sat=0, hist=0, fill=0, pat=RST_PAT, len=RST_LEN.

## Timing
- Latency: z rises after the clk edge that accepts the completing bit. It is valid from that edge until the next edge, and is sampled by benches #1 after the rising edge.
- match_count updates on the same edge as z.
- x_valid=0 stalls: hist/fill/count hold, z returns to 0 on that edge.
- load: the new pattern applies to the first accepted bit on the following edge.
- An asynchronous reset mid-stream clears state immediately. The first accepted bit after release starts with fill=0.
- Inputs must be stable around the rising edge. Benches drive on the falling edge.

## Configuration
- SEQDET_COUNT_EN defined: match counter, clr_count and count_sat are implemented as above.
- SEQDET_COUNT_EN undefined: no counter flops. match_count is tied to 0, count_sat is tied to 0, and clr_count is ignored. z behaviour is unchanged.

## Test plan
- Reset defaults, overlap_en=1, stream 1,1,0,1,1,0,1 → z pulses after bits 4 and 7 only; match_count=2.
- Same stream, overlap_en=0 → z after bit 4 only; match_count=1.
- Load pat_in=3'b111, len_in=3, then stream 1,1,1,1,1:
  - overlap_en=1 → z after bits 3, 4 and 5; count=3.
  - overlap_en=0 → z after bit 3 only.
- Default pattern, stream 1,1,0 then x_valid=0 for 3 cycles, then 1 → z stays 0 during the gap and pulses once after the final 1.
- Load during a partial match (after 1,1,0) with len_in=0, pat_in=1 → len=1; each subsequent accepted 1 pulses z. The load-edge x is ignored.
- CNT_W=2: 4 matches → count=3, count_sat=1. clr_count asserted on the same edge as a fifth match → count=0 and z=1. Without SEQDET_COUNT_EN, count stays 0 throughout.
